parking_slot_access_manager: RTL

//  Parametrised registration controller for the smart parking system.
//  - Verifies a user token against the system token and confirms the request.
//  - Allocates the lowest free slot from an N_SLOTS occupancy map.
//  - Classifies each grant as peak (reg_p) or normal (reg_q) from time_data.
//  - Sits between the keypad/token front end and the billing/display blocks; also services slot releases.

---
 rtl/parking_slot_access_manager_if.sv | 35 +++
 rtl/parking_slot_access_manager.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_access_manager_if.sv
// Front-end / billing bus of the parking slot access manager.
// The master drives the request side and the slave returns registration status and the slot map.
interface parking_slot_access_manager_if #(
  parameter int unsigned TOKEN_W = 3,
  parameter int unsigned TIME_W  = 8,
  parameter int unsigned N_SLOTS = 4
);
  localparam int unsigned SLOT_W = $clog2(N_SLOTS);

  logic               request;
  logic               confirm;
  logic [TOKEN_W-1:0] system_token;
  logic [TOKEN_W-1:0] user_token;
  logic [TIME_W-1:0]  time_data;
  logic               release_valid;
  logic [SLOT_W-1:0]  release_slot;
  logic               reg_p;
  logic               reg_q;
  logic               granted;
  logic [SLOT_W-1:0]  slot_id;
  logic               denied;
  logic               locked;
  logic               full;
  logic [N_SLOTS-1:0] occupancy;

  modport master (
    output request, confirm, system_token, user_token, time_data, release_valid, release_slot,
    input  reg_p, reg_q, granted, slot_id, denied, locked, full, occupancy
  );

  modport slave (
    input  request, confirm, system_token, user_token, time_data, release_valid, release_slot,
    output reg_p, reg_q, granted, slot_id, denied, locked, full, occupancy
  );
endinterface

// File: rtl/parking_slot_access_manager.sv
// Token-verified slot registration controller with peak/normal classification and slot release.
// Define SAM_LOCKOUT_EN to enable the retry counter and LOCKOUT state.
module parking_slot_access_manager #(
  parameter int unsigned        TOKEN_W     = 3,
  parameter int unsigned        TIME_W      = 8,
  parameter int unsigned        N_SLOTS     = 4,
  parameter logic [TIME_W-1:0]  PEAK_START  = 8'hF0,
  parameter int unsigned        TIMEOUT_CYC = 16
`ifdef SAM_LOCKOUT_EN
  ,
  parameter int unsigned        MAX_RETRY   = 3
`endif
) (
  input logic clock,
  input logic reset,
  parking_slot_access_manager_if.slave bus
);
  localparam int unsigned SLOT_W = $clog2(N_SLOTS);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
`ifdef SAM_LOCKOUT_EN
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_VERIFIED, S_COMMIT, S_DENIED, S_LOCKOUT
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               reg_p_q, reg_p_d;
  logic               reg_q_q, reg_q_d;
  logic               granted_q, granted_d;
  logic               denied_q, denied_d;
  logic [SLOT_W-1:0]  slot_id_q, slot_id_d;
  logic [N_SLOTS-1:0] occ_q, occ_d;
  logic [N_SLOTS-1:0] grant_mask, rel_mask;
  logic [SLOT_W-1:0]  free_idx;
  logic               map_full, token_ok, peak;
`ifdef SAM_LOCKOUT_EN
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               locked_q;
`endif

  assign map_full = &occ_q;
  assign token_ok = (bus.user_token == bus.system_token);
  assign peak     = (bus.time_data >= PEAK_START);

  // Lowest-index free slot in the pre-release map
  always_comb begin : free_search
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (!found && !occ_q[i]) begin
        free_idx = SLOT_W'(i);
        found    = 1'b1;
      end
    end
  end

  // Releases only clear bits that are currently set and in range
  always_comb begin : release_decode
    rel_mask = '0;
    if (bus.release_valid && (32'(bus.release_slot) < N_SLOTS))
      rel_mask[bus.release_slot] = occ_q[bus.release_slot];
  end

  always_comb begin : fsm_next
    state_d    = state_q;
    timer_d    = '0;
    reg_p_d    = 1'b0;
    reg_q_d    = 1'b0;
    granted_d  = 1'b0;
    slot_id_d  = '0;
    grant_mask = '0;
`ifdef SAM_LOCKOUT_EN
    retry_d    = retry_q;
`endif
    if (state_q != S_LOCKOUT && !bus.request) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = map_full ? S_DENIED : S_WAIT;
        S_WAIT: begin
          if (bus.confirm) begin
            if (token_ok) begin
              state_d = S_VERIFIED;
`ifdef SAM_LOCKOUT_EN
              retry_d = '0;
`endif
            end else begin
              state_d = S_DENIED;
`ifdef SAM_LOCKOUT_EN
              if (retry_q == RETRY_MAX) state_d = S_LOCKOUT;
              else                      retry_d = retry_q + 1'b1;
`endif
            end
          end else if (timer_q == TMR_LAST) begin
            state_d = S_DENIED;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_VERIFIED: begin
          if (!bus.confirm) begin
            state_d = S_WAIT;
          end else if (map_full) begin
            state_d = S_DENIED;
          end else begin
            state_d              = S_COMMIT;
            grant_mask[free_idx] = 1'b1;
            slot_id_d            = free_idx;
            reg_p_d              = peak;
            reg_q_d              = !peak;
            granted_d            = 1'b1;
          end
        end
        S_COMMIT: begin
          reg_p_d   = reg_p_q;
          reg_q_d   = reg_q_q;
          slot_id_d = slot_id_q;
        end
        S_DENIED: state_d = S_DENIED;
`ifdef SAM_LOCKOUT_EN
        // Exit needs TIMEOUT_CYC consecutive request-low cycles
        S_LOCKOUT: begin
          if (bus.request) begin
            timer_d = '0;
          end else if (timer_q == TMR_LAST) begin
            state_d = S_IDLE;
            retry_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    denied_d = (state_d == S_DENIED);
    occ_d    = (occ_q & ~rel_mask) | grant_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      reg_p_q   <= 1'b0;
      reg_q_q   <= 1'b0;
      granted_q <= 1'b0;
      denied_q  <= 1'b0;
      slot_id_q <= '0;
      occ_q     <= '0;
`ifdef SAM_LOCKOUT_EN
      retry_q   <= '0;
      locked_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      reg_p_q   <= reg_p_d;
      reg_q_q   <= reg_q_d;
      granted_q <= granted_d;
      denied_q  <= denied_d;
      slot_id_q <= slot_id_d;
      occ_q     <= occ_d;
`ifdef SAM_LOCKOUT_EN
      retry_q   <= retry_d;
      locked_q  <= (state_d == S_LOCKOUT);
`endif
    end
  end

  assign bus.reg_p     = reg_p_q;
  assign bus.reg_q     = reg_q_q;
  assign bus.granted   = granted_q;
  assign bus.slot_id   = slot_id_q;
  assign bus.denied    = denied_q;
  assign bus.full      = map_full;
  assign bus.occupancy = occ_q;
`ifdef SAM_LOCKOUT_EN
  assign bus.locked    = locked_q;
`else
  assign bus.locked    = 1'b0;
`endif
endmodule
